// File: rtl/ps2_mouse_pkg.sv
// ps2_mouse_pkg
// Shared definitions for the PS/2 mouse packet receiver:
//   - bit_state_t : states of the per-byte serial frame FSM
//   - field positions of the 32-bit packet word presented to the PIO
//   - SYNC_BIT    : bit of the first packet byte that is always 1 on a real mouse
//   - pack_word() : assembles the published packet word from its fields
package ps2_mouse_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } bit_state_t;

   localparam int VALID_BIT  = 31;
   localparam int ERR_BIT    = 29;
   localparam int SEQ_LSB    = 24;
   localparam int DY_LSB     = 16;
   localparam int DX_LSB     = 8;
   localparam int STATUS_LSB = 0;
   localparam int SYNC_BIT   = 3;

   // Builds the word software reads; bits 30 and 28 are reserved and stay 0.
   function automatic logic [31:0] pack_word(input logic       err,
                                             input logic [3:0] seq,
                                             input logic [7:0] dy,
                                             input logic [7:0] dx,
                                             input logic [7:0] status);
      logic [31:0] w;
      w                     = '0;
      w[VALID_BIT]          = 1'b1;
      w[ERR_BIT]            = err;
      w[SEQ_LSB    +: 4]    = seq;
      w[DY_LSB     +: 8]    = dy;
      w[DX_LSB     +: 8]    = dx;
      w[STATUS_LSB +: 8]    = status;
      return w;
   endfunction

endpackage

// File: rtl/ps2_line_cond.sv
// ps2_line_cond
// Conditions the asynchronous PS/2 pins for the receiver.
//   clk       : system clock
//   reset     : synchronous active-high reset (lines treated as idle-high)
//   ps2_clk   : raw PS/2 clock pin
//   ps2_data  : raw PS/2 data pin
//   fall      : one-cycle pulse when the filtered PS/2 clock goes 1->0
//   sync_data : synchronised PS/2 data, valid to sample when fall is high
module ps2_line_cond #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic fall,
   output logic sync_data
);

   localparam int CW = $clog2(FILTER_LEN) + 1;

   logic [1:0]    clk_sync;
   logic [1:0]    data_sync;
   logic          sync_clk;
   logic          filt_clk;
   logic [CW-1:0] filt_cnt;

   assign sync_clk  = clk_sync[1];
   assign sync_data = data_sync[1];

   // Two-stage synchronisers, then a run-length filter: filt_clk only moves
   // to the synchronised level after FILTER_LEN consecutive samples that
   // disagree with it, so short glitches never reach the bit FSM. The fall
   // pulse is raised in the same cycle filt_clk drops.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         filt_clk  <= 1'b1;
         filt_cnt  <= '0;
         fall      <= 1'b0;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
         fall      <= 1'b0;
         if (sync_clk == filt_clk) begin
            filt_cnt <= '0;
         end else if (filt_cnt == CW'(FILTER_LEN - 1)) begin
            filt_clk <= sync_clk;
            filt_cnt <= '0;
            fall     <= ~sync_clk;
         end else begin
            filt_cnt <= filt_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/ps2_mouse_packet_rx.sv
// ps2_mouse_packet_rx
// Receives device-to-host PS/2 mouse frames and assembles 3-byte movement
// packets into a status word for a 32-bit PIO input port.
//   clk           : system clock, rising edge
//   reset         : synchronous active-high reset
//   ps2_clk       : raw PS/2 clock pin (asynchronous)
//   ps2_data      : raw PS/2 data pin (asynchronous)
//   packet_word   : {valid, 0, err, 0, seq[3:0], dy, dx, status}
//   packet_strobe : one-cycle pulse when packet_word updates
//   frame_err     : one-cycle pulse on a parity or stop-bit error
module ps2_mouse_packet_rx
   import ps2_mouse_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [31:0] packet_word,
   output logic        packet_strobe,
   output logic        frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          fall;
   logic          sync_data;
   bit_state_t    state;
   bit_state_t    state_nxt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift_reg;
   logic          parity_bit;
   logic [1:0]    byte_idx;
   logic [7:0]    status_byte;
   logic [7:0]    dx_byte;
   logic [3:0]    seq;
   logic          err_pend;
   logic [TW-1:0] idle_cnt;
   logic          timeout;
   logic          byte_done;
   logic          byte_good;

   ps2_line_cond #(
      .FILTER_LEN(FILTER_LEN)
   ) u_line_cond (
      .clk      (clk),
      .reset    (reset),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .fall     (fall),
      .sync_data(sync_data)
   );

   // Bit FSM next state. A timeout only matters while something is half
   // received; a fall in the same cycle counts as activity and wins.
   always_comb begin
      state_nxt = state;
      byte_done = 1'b0;
      byte_good = 1'b0;
      timeout   = ((state != IDLE) || (byte_idx != 2'd0)) &&
                  (idle_cnt == TW'(TIMEOUT_CYCLES)) && !fall;
      if (timeout) begin
         state_nxt = IDLE;
      end else if (fall) begin
         case (state)
            IDLE:    if (!sync_data) state_nxt = DATA;
            DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
            PARITY:  state_nxt = STOP;
            STOP: begin
               state_nxt = IDLE;
               byte_done = 1'b1;
               byte_good = sync_data && (^{shift_reg, parity_bit});
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Datapath: bit shifting, byte assembly and publishing. A bad byte always
   // restarts the packet at the sync byte, because any byte position is
   // ambiguous after a lost frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt       <= '0;
         shift_reg     <= '0;
         parity_bit    <= 1'b0;
         byte_idx      <= '0;
         status_byte   <= '0;
         dx_byte       <= '0;
         seq           <= '0;
         err_pend      <= 1'b0;
         idle_cnt      <= '0;
         packet_word   <= '0;
         packet_strobe <= 1'b0;
         frame_err     <= 1'b0;
      end else begin
         packet_strobe <= 1'b0;
         frame_err     <= 1'b0;

         if (fall)                               idle_cnt <= '0;
         else if (idle_cnt != TW'(TIMEOUT_CYCLES)) idle_cnt <= idle_cnt + TW'(1);

         if (fall && state == IDLE) bit_cnt <= '0;
         if (fall && state == DATA) begin
            shift_reg <= {sync_data, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
         end
         if (fall && state == PARITY) parity_bit <= sync_data;

         if (timeout) begin
            byte_idx <= '0;
         end else if (byte_done && !byte_good) begin
            frame_err <= 1'b1;
            err_pend  <= 1'b1;
            byte_idx  <= '0;
         end else if (byte_done) begin
            case (byte_idx)
               2'd0: begin
                  if (shift_reg[SYNC_BIT]) begin
                     status_byte <= shift_reg;
                     byte_idx    <= 2'd1;
                  end
               end
               2'd1: begin
                  dx_byte  <= shift_reg;
                  byte_idx <= 2'd2;
               end
               default: begin
                  packet_word   <= pack_word(err_pend, seq + 4'd1, shift_reg,
                                             dx_byte, status_byte);
                  packet_strobe <= 1'b1;
                  seq           <= seq + 4'd1;
                  err_pend      <= 1'b0;
                  byte_idx      <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/ps2_mouse_packet_rx.md
Name: ps2_mouse_packet_rx

Overview:
Receives the raw PS/2 mouse serial stream (device-to-host only) and assembles standard 3-byte movement packets into a 32-bit status word. The block sits directly upstream of the 32-bit input PIO and drives its in_port. Software reads the word over Avalon and uses the sequence field to detect new packets. One clock domain; the PS/2 lines are asynchronous inputs.

Parameters:
FILTER_LEN, 8, consecutive identical synchronised ps2_clk samples required before the filtered clock changes (glitch reject)
TIMEOUT_CYCLES, 100000, idle clk cycles (2 ms at 50 MHz) before a partial frame or partial packet is abandoned

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock from the pin, asynchronous
ps2_data  input  1  raw PS/2 data from the pin, asynchronous
packet_word  output  32  packed packet to PIO in_port; layout given under Behaviour
packet_strobe  output  1  one-cycle pulse when packet_word updates
frame_err  output  1  one-cycle pulse on a parity or stop-bit error

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. Every register clears on the first clk edge with reset=1: packet_word=0, packet_strobe=0, frame_err=0, seq=0, err_pend=0, bit FSM in IDLE, byte index 0. Filter state resets to 1 (bus idle).
- Input conditioning: ps2_clk and ps2_data each pass through a 2-FF synchroniser. A saturating counter makes filt_clk follow sync_clk only after FILTER_LEN equal samples. A falling edge is filt_clk going 1->0 and is registered as a single-cycle fall pulse. Data is sampled from sync_data in the cycle of fall.
- Bit FSM (states IDLE, DATA, PARITY, STOP):
  - IDLE: fall with data=0 -> DATA, bitcnt=0. fall with data=1 is ignored.
  - DATA: on fall, shift the bit in LSB first; after the 8th bit -> PARITY.
  - PARITY: on fall, capture the parity bit -> STOP.
  - STOP: on fall -> IDLE. The byte is good only if data=1 and (8 data bits + parity) contain an odd number of ones.
  - Bad byte: pulse frame_err for 1 cycle, set err_pend, reset byte index to 0, discard the byte.
- Timeout: an idle counter clears on every fall. If the FSM is not in IDLE, or the byte index is not 0, and the counter reaches TIMEOUT_CYCLES, then FSM -> IDLE and byte index -> 0. A timeout does not set err_pend and does not pulse frame_err.
- Byte assembly:
  - Index 0: accept the byte only if bit3=1 (sync bit); otherwise drop it silently and stay at index 0.
  - Index 1 (dx) and index 2 (dy) are accepted unconditionally.
- Publish: one cycle after the good stop bit of byte 2 is sampled:
  - packet_word = {1'b1, 1'b0, err_pend, 1'b0, seq+1 (4 bits), dy, dx, status}
  - seq increments and wraps mod 16 (15 -> 0).
  - packet_strobe=1 for exactly 1 cycle.
  - err_pend clears, byte index -> 0.
- packet_word holds its value between publishes. Bit 31 stays 0 until the first publish after reset.
- Reset during a frame: the partial frame is discarded and packet_word returns to 0.
- A fall during reset is ignored.

Decomposition:
- Package ps2_mouse_pkg holds:
  - FSM state enum (IDLE, DATA, PARITY, STOP)
  - packet_word field bit positions: VALID_BIT=31, ERR_BIT=29, SEQ_LSB=24, DY_LSB=16, DX_LSB=8, STATUS_LSB=0
  - SYNC_BIT=3
- One sub-module, ps2_line_cond: the 2-FF synchronisers, the glitch filter and fall pulse generation. It outputs fall and sync_data.

Test Plan:
- Good packet: send bytes 0x08, 0x05, 0xFB with valid odd parity and 40 us bit period -> exactly one packet_strobe, packet_word=0x81FB0508, frame_err never pulses.
- Parity error: byte 0x09, then 0x10 with the wrong parity bit, then the full packet 0x09, 0x10, 0x20 -> one frame_err pulse, no strobe for the bad packet, then packet_word=0xA2201009 (err set, seq=2). The following good packet has bit29=0.
- Sync resync: send 0x00 (bit3=0), then 0x18, 0x01, 0x02 -> 0x00 is dropped silently, one strobe, packet_word[23:0]=0x020118, seq increments by 1 only.
- Timeout: send start plus 4 data bits, hold ps2_clk high for TIMEOUT_CYCLES+10, then the packet 0x08, 0x05, 0xFB -> no frame_err, one strobe with the correct word. Also: byte0 alone followed by a gap above the timeout is discarded.
- Glitch and seq wrap:
  - A ps2_clk low pulse of FILTER_LEN-1 cycles mid-frame produces no bit shift.
  - 16 consecutive good packets leave seq=0 in bits 27:24.
- Reset mid-frame: assert reset for 1 cycle during DATA bit 4 -> next cycle packet_word=0, packet_strobe=0. A subsequent full packet publishes with seq=1.
